acc_op_sequencer: RTL and testbench

//  Command-driven controller for the WIDTH-bit accumulator register. Accepts one op per

---
 rtl/acc_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_acc_op_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/acc_op_sequencer.sv
// Accumulator command sequencer: single-cycle CLR/LOAD/ADD/SUB, 16-cycle shift-add MUL.
// Latency: EXEC one cycle after accept, MUL retires WIDTH+1 cycles after accept; cmd_ready only in IDLE.
module acc_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] acc_q,
    output logic [WIDTH-1:0] acc_in,
    output logic             acc_load,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL_RUN, S_WRITE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_data;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic               r_ovf;

    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_acc_in;
    logic               w_acc_load;
    logic               w_done;
    logic               w_err;
    logic               w_ovf_we;
    logic               w_ovf_nxt;

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign busy      = (r_state != S_IDLE);
    assign acc_in    = w_acc_in;
    assign acc_load  = w_acc_load;
    assign done      = w_done;
    assign err       = w_err;
    assign ovf       = r_ovf;

    assign w_sum    = {1'b0, acc_q} + {1'b0, r_data};
    assign w_diff   = acc_q - r_data;
    assign w_borrow = (acc_q < r_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_acc_in   = '0;
        w_acc_load = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_ovf_we   = 1'b0;
        w_ovf_nxt  = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = (cmd_op == OP_MUL) ? S_MUL_RUN : S_EXEC;
            end
            S_EXEC: begin
                w_done = 1'b1;
                w_next = S_IDLE;
                case (r_op)
                    OP_NOP:  ;
                    OP_CLR:  w_acc_load = 1'b1;
                    OP_LOAD: begin
                        w_acc_in   = r_data;
                        w_acc_load = 1'b1;
                    end
                    OP_ADD: begin
                        w_acc_in   = w_sum[WIDTH-1:0];
                        w_acc_load = 1'b1;
                        w_ovf_we   = 1'b1;
                        w_ovf_nxt  = w_sum[WIDTH];
                    end
                    OP_SUB: begin
                        w_acc_in   = w_diff;
                        w_acc_load = 1'b1;
                        w_ovf_we   = 1'b1;
                        w_ovf_nxt  = w_borrow;
                    end
                    default: w_err = 1'b1;
                endcase
            end
            S_MUL_RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_acc_in   = r_prod[WIDTH-1:0];
                w_acc_load = 1'b1;
                w_done     = 1'b1;
                w_ovf_we   = 1'b1;
                w_ovf_nxt  = |r_prod[2*WIDTH-1:WIDTH];
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Shift-add multiplier always runs the full WIDTH iterations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_data   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
                if (cmd_op == OP_MUL) begin
                    r_mcand  <= {{WIDTH{1'b0}}, acc_q};
                    r_mplier <= cmd_data;
                    r_prod   <= '0;
                    r_cnt    <= '0;
                end
            end
            if (r_state == S_MUL_RUN) begin
                if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
            if (w_ovf_we) r_ovf <= w_ovf_nxt;
        end
    end
endmodule

// File: tb/tb_acc_op_sequencer.sv
// Directed bench for acc_op_sequencer with a behavioural accumulator register fed by acc_load/acc_in.
module tb_acc_op_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [15:0] acc_q;
    logic [15:0] acc_in;
    logic        acc_load;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        err;

    logic [15:0] acc_reg = 16'h0;
    int n_checks = 0;
    int n_err    = 0;

    acc_op_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .acc_q(acc_q), .acc_in(acc_in),
        .acc_load(acc_load), .busy(busy), .done(done), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (acc_load) acc_reg <= acc_in;
    assign acc_q = acc_reg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and observe it until busy drops; counts are per cycle at negedges.
    task automatic send(input logic [2:0] op, input logic [15:0] data,
                        output int nbusy, output int nload, output int ndone,
                        output int nerr, output int done_at);
        nbusy = 0; nload = 0; ndone = 0; nerr = 0; done_at = -1;
        @(negedge clk);
        cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        check("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (acc_load) nload++;
            if (err) nerr++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i + 1;
            end
            if (!busy) break;
        end
    endtask

    task automatic op_chk(input string tag, input logic [2:0] op, input logic [15:0] data,
                          input int exp_busy, input int exp_load, input int exp_err,
                          input logic [15:0] exp_acc, input logic exp_ovf);
        int nb, nl, nd, ne, da;
        send(op, data, nb, nl, nd, ne, da);
        check($sformatf("%s_busy_cycles", tag), nb, exp_busy);
        check($sformatf("%s_loads", tag), nl, exp_load);
        check($sformatf("%s_done_pulses", tag), nd, 1);
        check($sformatf("%s_done_cycle", tag), da, exp_busy);
        check($sformatf("%s_err", tag), ne, exp_err);
        check($sformatf("%s_acc", tag), acc_reg, exp_acc);
        check($sformatf("%s_ovf", tag), ovf, exp_ovf);
    endtask

    initial begin
        int accepts, last, gap_bad, rdy_bad, loads_in_rst;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 16'h0;
        #1;
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_load", acc_load, 0);
        check("rst_acc_in", acc_in, 0);
        check("rst_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("ready_after_rst", cmd_ready, 1);

        // Single-cycle ops
        op_chk("load1234", 3'd2, 16'h1234, 1, 1, 0, 16'h1234, 1'b0);
        op_chk("add1",     3'd3, 16'h0001, 1, 1, 0, 16'h1235, 1'b0);
        op_chk("loadffff", 3'd2, 16'hFFFF, 1, 1, 0, 16'hFFFF, 1'b0);
        op_chk("add2wrap", 3'd3, 16'h0002, 1, 1, 0, 16'h0001, 1'b1);
        op_chk("sub2wrap", 3'd4, 16'h0002, 1, 1, 0, 16'hFFFF, 1'b1);

        // MUL
        op_chk("load7",    3'd2, 16'd7,    1,  1, 0, 16'd7,    1'b1);
        op_chk("mul9",     3'd5, 16'd9,    17, 1, 0, 16'd63,   1'b0);
        op_chk("load300",  3'd2, 16'd300,  1,  1, 0, 16'd300,  1'b0);
        op_chk("mul300",   3'd5, 16'd300,  17, 1, 0, 16'h5F90, 1'b1);

        // Back-to-back ADD 1 with valid held high
        op_chk("clr0",     3'd1, 16'hABCD, 1, 1, 0, 16'h0000, 1'b1);
        accepts = 0; last = -1; gap_bad = 0; rdy_bad = 0;
        @(negedge clk);
        cmd_op = 3'd3; cmd_data = 16'h0001; cmd_valid = 1'b1;
        for (int c = 0; c < 40 && accepts < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (busy && cmd_ready) rdy_bad++;
            if (cmd_ready) begin
                if (last >= 0 && (c - last) != 2) gap_bad++;
                last = c;
                accepts++;
            end
            @(posedge clk);
            #1 if (accepts == 4) cmd_valid = 1'b0;
        end
        @(negedge clk);
        if (busy && cmd_ready) rdy_bad++;
        @(negedge clk);
        check("b2b_accepts", accepts, 4);
        check("b2b_gap", gap_bad, 0);
        check("b2b_ready_while_busy", rdy_bad, 0);
        check("b2b_acc", acc_reg, 16'd4);
        check("b2b_ovf", ovf, 0);

        // Illegal ops, NOP, CLR
        op_chk("addffff",  3'd3, 16'hFFFF, 1, 1, 0, 16'h0003, 1'b1);
        op_chk("illegal6", 3'd6, 16'h1111, 1, 0, 1, 16'h0003, 1'b1);
        op_chk("illegal7", 3'd7, 16'h2222, 1, 0, 1, 16'h0003, 1'b1);
        op_chk("nop",      3'd0, 16'h3333, 1, 0, 0, 16'h0003, 1'b1);
        op_chk("clr",      3'd1, 16'h4444, 1, 1, 0, 16'h0000, 1'b1);

        // Reset in the 5th MUL_RUN cycle
        op_chk("load5",    3'd2, 16'd5, 1, 1, 0, 16'd5, 1'b1);
        @(negedge clk);
        cmd_op = 3'd5; cmd_data = 16'd3; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_mul_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_load", acc_load, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_acc_in", acc_in, 0);
        check("mid_rst_ovf", ovf, 0);
        loads_in_rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (acc_load) loads_in_rst++;
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_load) loads_in_rst++;
        end
        check("mid_rst_no_load", loads_in_rst, 0);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_acc", acc_reg, 16'd5);
        op_chk("mul6",     3'd5, 16'd6, 17, 1, 0, 16'd30, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
